tone_sequencer: RTL and testbench



---
 rtl/tone_pkg.sv | 26 ++
 rtl/tone_rom.sv | 37 +++
 rtl/tone_sequencer.sv | 168 ++++++++++++++++
 tb/tb_tone_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer.
// States plus 50 MHz phase increments for one octave.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [31:0] NOTE_C4   = 32'd22474;
  localparam logic [31:0] NOTE_D4   = 32'd25225;
  localparam logic [31:0] NOTE_E4   = 32'd28315;
  localparam logic [31:0] NOTE_F4   = 32'd29999;
  localparam logic [31:0] NOTE_G4   = 32'd33673;
  localparam logic [31:0] NOTE_A4   = 32'd37796;
  localparam logic [31:0] NOTE_B4   = 32'd42424;
  localparam logic [31:0] NOTE_C5   = 32'd44948;
  localparam logic [31:0] NOTE_REST = 32'd0;

  // A zero increment is a rest: the buzzer stays gated off.
  function automatic logic is_tone(input logic [31:0] p);
    return p != NOTE_REST;
  endfunction

endpackage

// File: rtl/tone_rom.sv
// Melody table: 4-bit note index to 32-bit phase increment.
// Ports: i_idx (note index), o_data (increment, 0 = rest).
module tone_rom
  import tone_pkg::*;
#(
  parameter int unsigned NUM_NOTES = 8,
  parameter logic [15:0] REST_MASK = 16'h0000
) (
  input  logic [3:0]  i_idx,
  output logic [31:0] o_data
);

  localparam logic [4:0] NN = 5'(NUM_NOTES);

  logic [31:0] w_raw;
  logic        w_mute;

  always_comb begin
    w_raw = NOTE_REST;
    unique case (i_idx)
      4'd0:    w_raw = NOTE_C4;
      4'd1:    w_raw = NOTE_D4;
      4'd2:    w_raw = NOTE_E4;
      4'd3:    w_raw = NOTE_F4;
      4'd4:    w_raw = NOTE_G4;
      4'd5:    w_raw = NOTE_A4;
      4'd6:    w_raw = NOTE_B4;
      4'd7:    w_raw = NOTE_C5;
      default: w_raw = NOTE_REST;
    endcase
  end

  // Entries beyond the melody length, or masked, read as rests.
  assign w_mute = ({1'b0, i_idx} >= NN) || REST_MASK[i_idx];
  assign o_data = w_mute ? NOTE_REST : w_raw;

endmodule

// File: rtl/tone_sequencer.sv
// Steps a melody table and feeds period/duty words to the PWM.
// Ports: clk, rst (async high), start, stop in; period, duty,
// tone_en, busy, done, note_idx out. Option: TONE_SEQ_LOOP_EN
// makes playback repeat until stop/rst.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 12_500_000,
  parameter int unsigned GAP_TICKS  = 1_250_000,
  parameter int unsigned NUM_NOTES  = 8,
  parameter logic [31:0] DUTY_WORD  = 32'h8000_0000,
  parameter logic [15:0] REST_MASK  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] period,
  output logic [31:0] duty,
  output logic        tone_en,
  output logic        busy,
  output logic        done,
  output logic [3:0]  note_idx
);

  localparam logic [31:0] NT_LAST = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] GT_LAST =
    (GAP_TICKS > 0) ? 32'(GAP_TICKS - 1) : 32'd0;
  localparam logic [3:0]  LAST_IDX = 4'(NUM_NOTES - 1);
  localparam bit          HAS_GAP  = (GAP_TICKS > 0);

  state_t      r_state, w_state;
  logic [31:0] r_timer, w_timer;
  logic [31:0] r_period, w_period;
  logic [31:0] r_duty, w_duty;
  logic        r_tone_en, w_tone_en;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [3:0]  r_note_idx, w_note_idx;
  logic        w_adv;
  logic        w_last;
  logic [3:0]  w_rom_addr;
  logic [31:0] w_rom_data;

  assign w_last = (r_note_idx == LAST_IDX);

  // The ROM always presents the entry that would be loaded next.
  assign w_rom_addr = (r_state == IDLE || w_last) ?
                      4'd0 : r_note_idx + 4'd1;

  tone_rom #(
    .NUM_NOTES (NUM_NOTES),
    .REST_MASK (REST_MASK)
  ) u_rom (
    .i_idx  (w_rom_addr),
    .o_data (w_rom_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_period   <= '0;
      r_duty     <= '0;
      r_tone_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_note_idx <= '0;
    end else begin
      r_state    <= w_state;
      r_timer    <= w_timer;
      r_period   <= w_period;
      r_duty     <= w_duty;
      r_tone_en  <= w_tone_en;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_note_idx <= w_note_idx;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_timer    = r_timer;
    w_period   = r_period;
    w_duty     = r_duty;
    w_tone_en  = r_tone_en;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_note_idx = r_note_idx;
    w_adv      = 1'b0;
    if (stop) begin
      w_state    = IDLE;
      w_timer    = '0;
      w_period   = '0;
      w_duty     = '0;
      w_tone_en  = 1'b0;
      w_busy     = 1'b0;
      w_note_idx = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            w_state    = PLAY;
            w_timer    = '0;
            w_note_idx = '0;
            w_period   = w_rom_data;
            w_duty     = DUTY_WORD;
            w_tone_en  = is_tone(w_rom_data);
            w_busy     = 1'b1;
          end
        end
        PLAY: begin
          if (r_timer == NT_LAST) begin
            w_timer   = '0;
            w_tone_en = 1'b0;
            if (HAS_GAP) w_state = GAP;
            else         w_adv   = 1'b1;
          end else begin
            w_timer = r_timer + 32'd1;
          end
        end
        GAP: begin
          if (r_timer == GT_LAST) begin
            w_timer = '0;
            w_adv   = 1'b1;
          end else begin
            w_timer = r_timer + 32'd1;
          end
        end
        default: w_state = IDLE;
      endcase

      if (w_adv) begin
        if (w_last) begin
          w_done = 1'b1;
`ifdef TONE_SEQ_LOOP_EN
          w_state    = PLAY;
          w_note_idx = '0;
          w_period   = w_rom_data;
          w_duty     = DUTY_WORD;
          w_tone_en  = is_tone(w_rom_data);
`else
          w_state    = IDLE;
          w_busy     = 1'b0;
          w_period   = '0;
          w_duty     = '0;
          w_tone_en  = 1'b0;
          w_note_idx = '0;
`endif
        end else begin
          w_state    = PLAY;
          w_note_idx = r_note_idx + 4'd1;
          w_period   = w_rom_data;
          w_duty     = DUTY_WORD;
          w_tone_en  = is_tone(w_rom_data);
        end
      end
    end
  end

  assign period   = r_period;
  assign duty     = r_duty;
  assign tone_en  = r_tone_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign note_idx = r_note_idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: three configurations
// (gap, no gap, rest at note 2) share one random stimulus.
module tb_tone_sequencer;

  localparam int NT   = 4;
  localparam int NN   = 8;
  localparam int CYC  = 2500;
  localparam int RSTC = 1500;

  typedef struct {
    logic [31:0] period;
    logic [31:0] duty;
    logic        tone;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic stop  = 1'b0;

  logic [31:0] o_period [3];
  logic [31:0] o_duty   [3];
  logic        o_tone   [3];
  logic        o_busy   [3];
  logic        o_done   [3];
  logic [3:0]  o_idx    [3];

  exp_t q [3][$];
  bit   act [3];
  int   k   [3];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tone_sequencer #(
    .NOTE_TICKS (NT), .GAP_TICKS (2), .NUM_NOTES (NN)
  ) u0 (
    .clk (clk), .rst (rst), .start (start), .stop (stop),
    .period (o_period[0]), .duty (o_duty[0]),
    .tone_en (o_tone[0]), .busy (o_busy[0]),
    .done (o_done[0]), .note_idx (o_idx[0])
  );

  tone_sequencer #(
    .NOTE_TICKS (NT), .GAP_TICKS (0), .NUM_NOTES (NN)
  ) u1 (
    .clk (clk), .rst (rst), .start (start), .stop (stop),
    .period (o_period[1]), .duty (o_duty[1]),
    .tone_en (o_tone[1]), .busy (o_busy[1]),
    .done (o_done[1]), .note_idx (o_idx[1])
  );

  tone_sequencer #(
    .NOTE_TICKS (NT), .GAP_TICKS (2), .NUM_NOTES (NN),
    .REST_MASK (16'h0004)
  ) u2 (
    .clk (clk), .rst (rst), .start (start), .stop (stop),
    .period (o_period[2]), .duty (o_duty[2]),
    .tone_en (o_tone[2]), .busy (o_busy[2]),
    .done (o_done[2]), .note_idx (o_idx[2])
  );

  function automatic int gap_of(int i);
    return (i == 1) ? 0 : 2;
  endfunction

  function automatic logic [31:0] rom_val(int i, int idx);
    logic [31:0] mel [8];
    mel = '{32'd22474, 32'd25225, 32'd28315, 32'd29999,
            32'd33673, 32'd37796, 32'd42424, 32'd44948};
    if (idx >= NN) return 32'd0;
    if (i == 2 && idx == 2) return 32'd0;
    return mel[idx];
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.period = '0; e.duty = '0; e.tone = 1'b0;
    e.busy = 1'b0; e.done = 1'b0; e.idx = '0;
    return e;
  endfunction

  // Reference: a melody is just elapsed cycles since start,
  // split into fixed note slots of NT+gap cycles.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      bit   dn;
      int   p, idx, w;
      logic [31:0] f;
      dn = 1'b0;
      p  = NT + gap_of(i);
      if (rst || stop) begin
        act[i] = 1'b0;
      end else if (!act[i]) begin
        if (start) begin
          act[i] = 1'b1;
          k[i]   = 0;
        end
      end else begin
        k[i]++;
        if (k[i] == NN * p) begin
          dn = 1'b1;
`ifdef TONE_SEQ_LOOP_EN
          k[i] = 0;
`else
          act[i] = 1'b0;
`endif
        end
      end
      e = zero_exp();
      e.done = dn;
      if (act[i]) begin
        idx      = k[i] / p;
        w        = k[i] % p;
        f        = rom_val(i, idx);
        e.period = f;
        e.duty   = 32'h8000_0000;
        e.tone   = (w < NT) && (f != 0);
        e.busy   = 1'b1;
        e.idx    = 4'(idx);
      end
      q[i].push_back(e);
    end
  endtask

  task automatic cmp(int i, exp_t e, string tag);
    checks++;
    if (o_period[i] !== e.period || o_duty[i] !== e.duty ||
        o_tone[i] !== e.tone || o_busy[i] !== e.busy ||
        o_done[i] !== e.done || o_idx[i] !== e.idx) begin
      errors++;
      $display({"FAIL %s dut%0d t=%0t got p=%0d d=%h t=%b b=%b",
                " dn=%b i=%0d want p=%0d d=%h t=%b b=%b dn=%b i=%0d"},
        tag, i, $time, o_period[i], o_duty[i], o_tone[i],
        o_busy[i], o_done[i], o_idx[i], e.period, e.duty,
        e.tone, e.busy, e.done, e.idx);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() > 0) begin
        e = q[i].pop_front();
        cmp(i, e, "cycle");
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0;
      k[i]   = 0;
    end
    #2;
    for (int i = 0; i < 3; i++) cmp(i, zero_exp(), "reset");
    repeat (3) @(posedge clk);
    for (int c = 0; c < CYC; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      if (c == RSTC + 2) rst = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      if (c >= 150) begin
        start = ($urandom_range(0, 29) == 0);
        stop  = ($urandom_range(0, 199) == 0);
      end
      if (c == 10 || c == 20 || c == 70 || c == 100)
        start = 1'b1;
      if (c == 95) stop = 1'b1;
      if (c == 300) begin
        start = 1'b1;
        stop  = 1'b1;
      end
      if (c == RSTC - 10) begin
        start = 1'b1;
        stop  = 1'b0;
      end
      if (c > RSTC - 10 && c <= RSTC + 1) stop = 1'b0;
      model_step();
      if (c == RSTC) begin
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) cmp(i, zero_exp(), "async_rst");
      end
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d left=%0d want=0", i, q[i].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
